// File: rtl/prime_stream_gen_pkg.sv
// Shared types and constants for the prime stream generator.
// Optional feature macro used by this block: PRIME_SQRT_EN.
package prime_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int FIRST_PRIME   = 2;

    typedef enum logic [2:0] {
        IDLE,
        TEST,
        SUB,
        CHECK,
        EMIT,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/prime_stream_gen_if.sv
// Control, status and valid/ready prime stream bundle for prime_stream_gen.
// The master side requests enumeration and consumes primes; the slave side is the generator.
interface prime_stream_gen_if
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] upper;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_prime;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;

    modport master (
        output start, upper, out_ready,
        input  out_valid, out_prime, busy, done, count
    );

    modport slave (
        input  start, upper, out_ready,
        output out_valid, out_prime, busy, done, count
    );
endinterface

// File: rtl/prime_stream_gen_rem_sub.sv
// Running-remainder register for trial division: load a candidate, then
// subtract the divisor once per step; ge_o tells the FSM whether another step fits.
module rem_sub_unit
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             ge_o
);
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = load_val_i;
        end else if (step_i) begin
            rem_d = rem_q - div_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;
    assign ge_o  = (rem_q >= div_i);
endmodule

// File: rtl/prime_stream_gen.sv
// Streaming prime enumerator using subtract-only trial division.
// Define PRIME_SQRT_EN to stop trial division once div*div exceeds the candidate.
module prime_stream_gen
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    prime_stream_gen_if.slave bus
);
    state_t           state_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] ub_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] prime_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] rem;
    logic             rem_ge;
    logic             rem_load;
    logic             rem_step;
    logic             prime_hit;
    logic             start_ok;

`ifdef PRIME_SQRT_EN
    logic [WIDTH:0]   sq_q;
    logic [WIDTH:0]   sq_d;
    logic [WIDTH+1:0] sq_sum;

    // (d+1)^2 = d^2 + 2d + 1; saturate so a huge divisor never looks small again
    assign sq_sum    = {1'b0, sq_q} + {1'b0, div_q, 1'b1};
    assign sq_d      = sq_sum[WIDTH+1] ? '1 : sq_sum[WIDTH:0];
    assign prime_hit = (div_q == cand_q) || (sq_q > {1'b0, cand_q});
`else
    assign prime_hit = (div_q == cand_q);
`endif

    assign start_ok = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign rem_load = (state_q == TEST) && !prime_hit;
    assign rem_step = (state_q == SUB) && rem_ge;

    rem_sub_unit #(.WIDTH(WIDTH)) u_rem (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rem_load),
        .step_i     (rem_step),
        .load_val_i (cand_q),
        .div_i      (div_q),
        .rem_o      (rem),
        .ge_o       (rem_ge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            div_q   <= '0;
            ub_q    <= '0;
            count_q <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PRIME_SQRT_EN
            sq_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        cand_q  <= WIDTH'(FIRST_PRIME);
                        div_q   <= WIDTH'(2);
                        ub_q    <= bus.upper;
                        count_q <= '0;
`ifdef PRIME_SQRT_EN
                        sq_q    <= (WIDTH+1)'(4);
`endif
                        // A bound below the first prime has nothing to enumerate
                        if (bus.upper < WIDTH'(FIRST_PRIME)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= TEST;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                TEST: begin
                    if (prime_hit) begin
                        state_q <= EMIT;
                        valid_q <= 1'b1;
                        prime_q <= cand_q;
                    end else begin
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    if (!rem_ge) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (rem == '0) begin
                        state_q <= NEXT;
                    end else begin
                        div_q   <= div_q + 1'b1;
`ifdef PRIME_SQRT_EN
                        sq_q    <= sq_d;
`endif
                        state_q <= TEST;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 1'b1;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    // Compare before incrementing so an all-ones bound cannot wrap
                    if (cand_q == ub_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cand_q  <= cand_q + 1'b1;
                        div_q   <= WIDTH'(2);
`ifdef PRIME_SQRT_EN
                        sq_q    <= (WIDTH+1)'(4);
`endif
                        state_q <= TEST;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_prime = prime_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_prime_stream_gen.sv
// Directed self-checking bench for prime_stream_gen; expected primes and
// latencies are hand-derived. Honours PRIME_SQRT_EN when computing latency.
module tb_prime_stream_gen;
    import prime_pkg::*;

`ifdef PRIME_SQRT_EN
    localparam bit SQRT_EN = 1'b1;
`else
    localparam bit SQRT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    prime_stream_gen_if #(.WIDTH(16)) bus ();

    prime_stream_gen #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vecCount  = 0;
    int missCount = 0;
    int cycCount  = 0;
    int got[$];
    int expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each accepted prime on the negedge before the edge that transfers it
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got.push_back(int'(bus.out_prime));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkSeq(input string tag);
        int n;
        checkOutput({tag, "-len"}, got.size(), expQ.size());
        n = (got.size() < expQ.size()) ? got.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s-[%0d]", tag, i), got[i], expQ[i]);
        end
    endtask

    // Pulse start for one sampled edge; returns 2 time units after that edge
    task automatic applyStimulus(input logic [15:0] ub);
        @(posedge clk);
        #2;
        got.delete();
        bus.upper = ub;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        cycCount  = 0;
    endtask

    task automatic waitDone(input string tag);
        while (!bus.done && cycCount < 5000) begin
            @(posedge clk);
            #1;
            cycCount++;
        end
        checkOutput({tag, "-done"}, bus.done, 1);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "-valid"}, bus.out_valid, 1);
    endtask

    // Cycles from the start-sampling edge to DONE, from the per-candidate cost formula
    function automatic int modelCycles(input int ub);
        int cyc = 0;
        for (int c = 2; c <= ub; c++) begin
            bit isPrime = 1'b0;
            for (int d = 2; d <= c; d++) begin
                if (d == c || (SQRT_EN && d * d > c)) begin
                    cyc += 1;
                    isPrime = 1'b1;
                    break;
                end
                cyc += 3 + c / d;
                if (c % d == 0) break;
            end
            if (isPrime) cyc += 1;
            cyc += 1;
        end
        return cyc;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit stable;
        int n;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.upper     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst-valid", bus.out_valid, 0);
        checkOutput("rst-prime", bus.out_prime, 0);
        checkOutput("rst-busy",  bus.busy, 0);
        checkOutput("rst-done",  bus.done, 0);
        checkOutput("rst-count", bus.count, 0);
        #1;
        rst = 1'b0;

        // Free-running consumer, bound 10
        bus.out_ready = 1'b1;
        applyStimulus(16'd10);
        checkOutput("u10-busy0",  bus.busy, 1);
        checkOutput("u10-valid0", bus.out_valid, 0);
        @(posedge clk);
        #1;
        cycCount = 1;
        checkOutput("u10-valid1", bus.out_valid, 1);
        checkOutput("u10-prime1", bus.out_prime, 2);
        waitDone("u10");
        expQ = '{2, 3, 5, 7};
        checkSeq("u10");
        checkOutput("u10-count", bus.count, 4);
        checkOutput("u10-busy",  bus.busy, 0);
        checkOutput("u10-cycles", cycCount, modelCycles(10));

        // Back-pressure while 3 is presented
        bus.out_ready = 1'b0;
        applyStimulus(16'd10);
        waitValid("stall-2");
        checkOutput("stall-first", bus.out_prime, 2);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        waitValid("stall-3");
        checkOutput("stall-prime", bus.out_prime, 3);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.out_prime != 16'd3) stable = 1'b0;
        end
        checkOutput("stall-hold",   stable, 1);
        checkOutput("stall-noxfer", got.size(), 1);
        bus.out_ready = 1'b1;
        waitDone("stall");
        checkSeq("stall");
        checkOutput("stall-count", bus.count, 4);

        // Bound below the first prime
        applyStimulus(16'd1);
        @(posedge clk);
        #1;
        checkOutput("u1-done",  bus.done, 1);
        checkOutput("u1-busy",  bus.busy, 0);
        checkOutput("u1-count", bus.count, 0);
        checkOutput("u1-xfers", got.size(), 0);

        // Bound 30 with latency check
        applyStimulus(16'd30);
        waitDone("u30");
        expQ = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
        checkSeq("u30");
        checkOutput("u30-count",  bus.count, 10);
        checkOutput("u30-cycles", cycCount, modelCycles(30));

        // Asynchronous reset while cand 9 is in SUB
        applyStimulus(16'd20);
        n = 0;
        while (got.size() < 4 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rstmid-reach7", got.size(), 4);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rstmid-busy-pre", bus.busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid-valid", bus.out_valid, 0);
        checkOutput("rstmid-prime", bus.out_prime, 0);
        checkOutput("rstmid-busy",  bus.busy, 0);
        checkOutput("rstmid-done",  bus.done, 0);
        checkOutput("rstmid-count", bus.count, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(16'd5);
        waitDone("u5");
        expQ = '{2, 3, 5};
        checkSeq("u5");
        checkOutput("u5-count", bus.count, 3);

        // Start while busy is ignored; then restart from DONE
        applyStimulus(16'd10);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("midrun-busy", bus.busy, 1);
        bus.upper = 16'd100;
        bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        waitDone("midrun");
        expQ = '{2, 3, 5, 7};
        checkSeq("midrun");
        checkOutput("midrun-count", bus.count, 4);

        applyStimulus(16'd13);
        checkOutput("u13-count0", bus.count, 0);
        checkOutput("u13-done0",  bus.done, 0);
        waitDone("u13");
        expQ = '{2, 3, 5, 7, 11, 13};
        checkSeq("u13");
        checkOutput("u13-count", bus.count, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
